ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit that sits directly upstream of the single-cycle RV64 core and supplies its 32-bit `inst` word. It walks a fetch PC from a reset vector, issues one-outstanding doubleword reads on a request/grant/response memory port, and extracts the addressed 32-bit half. It buffers fetched instructions with their PCs in a small FIFO behind a valid/ready handshake, and flushes cleanly on a redirect from the core's branch/jump resolution.

## Interface
- `RESET_PC`, 64'h0000000080000000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries; power of 2, ≥2
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  64  new fetch PC; bits [1:0] ignored (treated as 0)
- `mem_req`  out  1  read request valid
- `mem_addr`  out  64  doubleword address = {fetch_pc[63:3], 3'b000}
- `mem_gnt`  in  1  request accepted this cycle (sampled only when `mem_req`=1)
- `mem_rvalid`  in  1  read data valid; exactly one per granted request, earliest 1 cycle after grant
- `mem_rdata`  in  64  read data
- `inst_valid`  out  1  FIFO head valid
- `inst`  out  32  FIFO head instruction
- `inst_pc`  out  64  PC of FIFO head instruction
- `inst_ready`  in  1  consumer accepts head this cycle

## Operation
- State: `fetch_pc` (64b), `req_pc` (64b, PC of outstanding request), FSM {REQ, WAIT, DROP}, FIFO of {pc, inst} with count 0..FIFO_DEPTH.
- REQ: `mem_req` = (count < FIFO_DEPTH). On `mem_req & mem_gnt`: `req_pc` <= `fetch_pc`, go WAIT.
- WAIT: `mem_req`=0. On `mem_rvalid`: push {`req_pc`, `req_pc[2]` ? `mem_rdata[63:32]` : `mem_rdata[31:0]`}; `fetch_pc` <= `req_pc` + 4 (64-bit wrap); go REQ.
- DROP: `mem_req`=0. On `mem_rvalid`: data discarded, go REQ.
- Pop: when `inst_valid & inst_ready`, head removed. Push and pop in the same cycle keep count unchanged. A push never overflows, because a request is issued only while count < FIFO_DEPTH and at most one request is outstanding.
- Redirect (`redirect_valid`=1) has priority over everything except `rst`:
  - FIFO flushed (count <= 0); a simultaneous pop or push is discarded.
  - `fetch_pc` <= {`redirect_pc[63:2]`, 2'b00}.
  - From REQ without grant: stay REQ; `mem_addr` follows the new PC next cycle.
  - From REQ with grant that cycle: go DROP.
  - From WAIT without `mem_rvalid`: go DROP.
  - From WAIT with `mem_rvalid`: response discarded, go REQ.
  - From DROP without `mem_rvalid`: stay DROP. From DROP with `mem_rvalid`: go REQ.
- `mem_addr` changes while `mem_req`=1 only after a redirect; otherwise it is stable until grant.
- Reset: `fetch_pc` <= RESET_PC, FSM <= REQ, FIFO emptied. An in-flight response arriving after `rst` deasserts is not tolerated; the memory model is reset together with the unit.

## Timing
- Reset values (during and the cycle after `rst`): `inst_valid`=0; `inst`, `inst_pc` = 0 (empty-FIFO outputs are forced to 0). `mem_req`=0 while `rst`=1, then 1 in the first cycle after deassertion, with `mem_addr`=RESET_PC.
- FIFO registers writes; `inst_valid` rises the cycle after the `mem_rvalid` push.
- Minimum latency from grant (cycle N) to `inst_valid`: rvalid at N+1, `inst_valid` at N+2.
- Peak throughput: one instruction per 2 cycles (REQ→WAIT→REQ with zero-wait memory).
- Redirect at cycle N: `inst_valid`=0 at N+1. The first post-redirect `mem_req` occurs at N+1 if no request is outstanding, else the cycle after the dropped `mem_rvalid`.
- `inst`/`inst_pc` stay stable while `inst_valid & !inst_ready`.

## Test plan
- Reset, memory returns `mem_rdata`=64'h00100073_00000413 with 1-cycle latency, `inst_ready`=1 → `inst_pc` 0x80000000 `inst` 0x00000413, then 0x80000004 `inst` 0x00100073; both `mem_addr`=0x80000000.
- `inst_ready`=0 for 10 cycles, FIFO_DEPTH=2 → exactly 2 grants, then `mem_req`=0. Releasing ready → head PCs 0x80000000, 0x80000004, 0x80000008 in order, none lost or duplicated.
- Redirect to 0x80000100 in the cycle after grant, `mem_rvalid` 3 cycles later → that response is dropped, next `mem_addr`=0x80000100, first `inst_pc`=0x80000100.
- Redirect in the same cycle as `mem_gnt` → state DROP, next response discarded, following request at redirect PC.
- Redirect coinciding with `mem_rvalid` and `inst_valid & inst_ready` → FIFO empty next cycle, no push, immediate `mem_req` at new PC.
- `rst` asserted mid-WAIT with 3 buffered instructions pending → `inst_valid`=0, first request after release at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: walks a fetch PC, issues one-outstanding doubleword reads,
// and buffers the selected 32-bit instruction with its PC in a small FIFO.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [63:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];

  logic gnt_fire, push, pop;
  logic [31:0] rsp_inst;

  // Handshakes: a request transfers on mem_req & mem_gnt; an instruction
  // leaves the buffer on inst_valid & inst_ready. A redirect kills both push and pop.
  assign gnt_fire = mem_req & mem_gnt;
  assign push     = (state_q == S_WAIT) & mem_rvalid & ~redirect_valid;
  assign pop      = inst_valid & inst_ready & ~redirect_valid;
  assign rsp_inst = req_pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (gnt_fire) req_pc_d = fetch_pc_q;
    if (push) fetch_pc_d = req_pc_q + 64'd4;
    if (redirect_valid) fetch_pc_d = redirect_pc & ~64'h3;
    case (state_q)
      S_REQ:   if (gnt_fire) state_d = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT:  begin
        if (mem_rvalid)          state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP:  if (mem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_REQ) && (count_q < CW'(FIFO_DEPTH)) && !rst;
    mem_addr  = fetch_pc_q & ~64'h7;
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        inst_mem_q[wr_ptr_q] <= rsp_inst;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Empty (or in-reset) buffer drives zeros so the core never sees stale data.
  always_comb begin
    inst_valid = (count_q != '0) && !rst;
    inst       = inst_valid ? inst_mem_q[rd_ptr_q] : 32'd0;
    inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : 64'd0;
  end

endmodule
